value_predict_table: RTL and testbench

- Parametrised last-value load predictor with per-entry confidence and an in-order queue of up to MAX_INFLIGHT outstanding predictions.
- Sits beside the hazard controller.
  - On a D-cache read miss, EX looks up the load PC. A confident hit supplies a speculative value; the pipeline commits to it with spec_accept.
  - Returning D-cache data resolves the oldest prediction. A mismatch raises a recover request carrying the checkpoint PC.
- Generalises the single-shot, single-entry predictor to an indexed table with multiple predictions in flight.

---
 rtl/value_predict_table.sv | 194 +++++++++++++++++++
 tb/tb_value_predict_table.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/value_predict_table.sv
// value_predict_table
//   Last-value load predictor. An indexed table of {valid, tag, value,
//   confidence} is looked up on an EX-stage D-cache miss. When the pipeline
//   accepts a confident prediction, {pc, value} is pushed onto an in-order
//   queue. Returning load data resolves the oldest entry: a match trains the
//   confidence up, a mismatch retrains the entry, clears the queue and
//   requests a checkpoint recovery.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   lookup_valid/pc       prediction request from EX
//   pred_valid/value      combinational prediction result
//   spec_accept           pipeline consumes the prediction (push)
//   spec_full             queue holds MAX_INFLIGHT entries
//   resolve_valid/data    true data for the oldest prediction (pop)
//   flush                 drop every outstanding prediction
//   recover, recover_pc   misprediction pulse and the offending load PC
//   recovery_done         checkpoint restore finished
//   correct               oldest prediction verified (pulse)
//   inflight_count        queue occupancy
//   overflow_err          sticky: push dropped because the queue was full
module value_predict_table #(
  parameter int DATA_WIDTH   = 32,
  parameter int INDEX_BITS   = 6,
  parameter int PC_LSB       = 2,
  parameter int CONF_BITS    = 2,
  parameter int CONF_THRESH  = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          lookup_valid,
  input  logic [DATA_WIDTH-1:0]         lookup_pc,
  output logic                          pred_valid,
  output logic [DATA_WIDTH-1:0]         pred_value,
  input  logic                          spec_accept,
  output logic                          spec_full,
  input  logic                          resolve_valid,
  input  logic [DATA_WIDTH-1:0]         resolve_data,
  input  logic                          flush,
  output logic                          recover,
  output logic [DATA_WIDTH-1:0]         recover_pc,
  input  logic                          recovery_done,
  output logic                          correct,
  output logic [$clog2(MAX_INFLIGHT):0] inflight_count,
  output logic                          overflow_err
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = DATA_WIDTH - PC_LSB - INDEX_BITS;
  localparam int QA_W    = $clog2(MAX_INFLIGHT);
  localparam int PTR_W   = QA_W + 1;
  localparam logic [CONF_BITS-1:0] CONF_MAX = '1;
  localparam logic [CONF_BITS-1:0] THRESH   = CONF_BITS'(CONF_THRESH);
  localparam logic [PTR_W-1:0]     Q_DEPTH  = PTR_W'(MAX_INFLIGHT);

  typedef enum logic [1:0] {S_RUN, S_RECOVER, S_WAIT} state_t;

  function automatic logic [INDEX_BITS-1:0] pc_index(input logic [DATA_WIDTH-1:0] pc);
    return pc[PC_LSB +: INDEX_BITS];
  endfunction

  function automatic logic [TAG_W-1:0] pc_tag(input logic [DATA_WIDTH-1:0] pc);
    return pc[DATA_WIDTH-1 : PC_LSB+INDEX_BITS];
  endfunction

  function automatic logic [CONF_BITS-1:0] conf_sat_inc(input logic [CONF_BITS-1:0] c);
    return (c == CONF_MAX) ? c : c + 1'b1;
  endfunction

  // Prediction table
  logic                  t_vld  [ENTRIES];
  logic [CONF_BITS-1:0]  t_conf [ENTRIES];
  logic [TAG_W-1:0]      t_tag  [ENTRIES];
  logic [DATA_WIDTH-1:0] t_val  [ENTRIES];

  // Outstanding-prediction queue; pointers carry one wrap bit so that
  // tail - head is the occupancy directly.
  logic [DATA_WIDTH-1:0] q_pc  [MAX_INFLIGHT];
  logic [DATA_WIDTH-1:0] q_val [MAX_INFLIGHT];
  logic [PTR_W-1:0]      head, tail;
  state_t                state;

  logic [INDEX_BITS-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0]      lk_tag, upd_tag;
  logic [QA_W-1:0]       head_slot, tail_slot;
  logic [PTR_W-1:0]      count;
  logic [DATA_WIDTH-1:0] upd_pc;
  logic run, full, empty, lk_hit;
  logic push_req, push_ok, pop, train, mismatch;
  logic upd_en, upd_hit, upd_same;

  always_comb begin
    lk_idx    = pc_index(lookup_pc);
    lk_tag    = pc_tag(lookup_pc);
    run       = (state == S_RUN);
    count     = tail - head;
    full      = (count == Q_DEPTH);
    empty     = (head == tail);
    head_slot = head[QA_W-1:0];
    tail_slot = tail[QA_W-1:0];

    lk_hit = lookup_valid & t_vld[lk_idx] & (t_tag[lk_idx] == lk_tag)
           & (t_conf[lk_idx] >= THRESH);

    // A push while full is still attempted so that a same-cycle pop can
    // make room; pred_valid itself stays low when full.
    push_req = spec_accept & lk_hit & run;
    pop      = resolve_valid & ~empty & run;
    train    = resolve_valid & empty & lookup_valid & run;
    mismatch = pop & (resolve_data != q_val[head_slot]);
    push_ok  = push_req & (~full | pop) & ~flush & ~mismatch;

    // Table update target: head PC on a pop, lookup PC when training only.
    upd_en   = pop | train;
    upd_pc   = pop ? q_pc[head_slot] : lookup_pc;
    upd_idx  = pc_index(upd_pc);
    upd_tag  = pc_tag(upd_pc);
    upd_hit  = t_vld[upd_idx] & (t_tag[upd_idx] == upd_tag);
    upd_same = pop ? ~mismatch : (t_val[upd_idx] == resolve_data);
  end

  assign pred_valid     = lk_hit & run & ~full;
  assign pred_value     = t_val[lk_idx];
  assign spec_full      = full;
  assign inflight_count = count;

  // Table control: validity and confidence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        t_vld[i]  <= 1'b0;
        t_conf[i] <= '0;
      end
    end else if (upd_en) begin
      t_vld[upd_idx]  <= 1'b1;
      t_conf[upd_idx] <= (upd_hit & upd_same) ? conf_sat_inc(t_conf[upd_idx]) : '0;
    end
  end

  // Table and queue payload
  always_ff @(posedge clk) begin
    if (upd_en) begin
      t_tag[upd_idx] <= upd_tag;
      t_val[upd_idx] <= resolve_data;
    end
    if (push_ok) begin
      q_pc[tail_slot]  <= lookup_pc;
      q_val[tail_slot] <= t_val[lk_idx];
    end
  end

  // Queue pointers, recovery FSM and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_RUN;
      head         <= '0;
      tail         <= '0;
      recover      <= 1'b0;
      recover_pc   <= '0;
      correct      <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      recover <= 1'b0;
      correct <= pop & ~mismatch;

      case (state)
        S_RUN: begin
          if (mismatch) begin
            state      <= S_RECOVER;
            recover    <= 1'b1;
            recover_pc <= q_pc[head_slot];
          end
        end
        S_RECOVER: state <= S_WAIT;
        S_WAIT:    if (recovery_done) state <= S_RUN;
        default:   state <= S_RUN;
      endcase

      // Mismatch and flush both empty the queue; anything pushed or
      // popped in the same cycle is discarded along with it.
      if (mismatch | flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push_ok) tail <= tail + 1'b1;
        if (pop)     head <= head + 1'b1;
      end

      if (push_req & full & ~pop) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_value_predict_table.sv
module tb_value_predict_table;

  logic        clk;
  logic        rst_n;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_valid;
  logic [31:0] pred_value;
  logic        spec_accept;
  logic        spec_full;
  logic        resolve_valid;
  logic [31:0] resolve_data;
  logic        flush;
  logic        recover;
  logic [31:0] recover_pc;
  logic        recovery_done;
  logic        correct;
  logic [2:0]  inflight_count;
  logic        overflow_err;

  value_predict_table #(
    .DATA_WIDTH(32), .INDEX_BITS(6), .PC_LSB(2),
    .CONF_BITS(2), .CONF_THRESH(2), .MAX_INFLIGHT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_value(pred_value),
    .spec_accept(spec_accept), .spec_full(spec_full),
    .resolve_valid(resolve_valid), .resolve_data(resolve_data),
    .flush(flush), .recover(recover), .recover_pc(recover_pc),
    .recovery_done(recovery_done), .correct(correct),
    .inflight_count(inflight_count), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit ovf_exp = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] val;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        do_train;
    logic [31:0] pc;
    logic [31:0] data;
    logic        exp_pv;
    logic [31:0] exp_val;
  } vec_t;
  vec_t vecs[19];

  logic [31:0] fp[4];
  logic [31:0] fv[4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lookup_valid  = 1'b0;
    lookup_pc     = '0;
    spec_accept   = 1'b0;
    resolve_valid = 1'b0;
    resolve_data  = '0;
    flush         = 1'b0;
    recovery_done = 1'b0;
  endtask

  task automatic lookup_check(input string name, input logic [31:0] pc,
                              input logic pv, input logic [31:0] val);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    #1;
    chk({name, " pred_valid"}, pred_valid, pv);
    if (pv) chk({name, " pred_value"}, pred_value, val);
    idle();
    tick();
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] data);
    lookup_valid  = 1'b1;
    lookup_pc     = pc;
    resolve_valid = 1'b1;
    resolve_data  = data;
    tick();
    idle();
    chk("train no correct", correct, 0);
    chk("train no recover", recover, 0);
  endtask

  // One cycle with an optional push and/or resolve; expectations come from
  // the scoreboard queue of accepted predictions.
  task automatic cyc(input logic p, input logic [31:0] ppc, input logic [31:0] pval,
                     input logic r, input logic [31:0] rdata);
    sb_t         e;
    logic        exp_corr, exp_rec;
    logic [31:0] exp_pc;
    lookup_valid  = p;
    lookup_pc     = ppc;
    spec_accept   = p;
    resolve_valid = r;
    resolve_data  = rdata;
    #1;
    if (p) chk("push pred_valid", pred_valid, (sb.size() < 4));
    exp_corr = 1'b0;
    exp_rec  = 1'b0;
    exp_pc   = '0;
    if (r && sb.size() > 0) begin
      e        = sb.pop_front();
      exp_corr = (rdata == e.val);
      exp_rec  = ~exp_corr;
      exp_pc   = e.pc;
    end
    if (exp_rec) sb.delete();
    else if (p && sb.size() < 4) sb.push_back('{ppc, pval});
    else if (p) ovf_exp = 1'b1;
    tick();
    idle();
    chk("correct", correct, exp_corr);
    chk("recover", recover, exp_rec);
    if (exp_rec) chk("recover_pc", recover_pc, exp_pc);
    chk("inflight_count", inflight_count, sb.size());
    chk("spec_full", spec_full, (sb.size() == 4));
    chk("overflow_err", overflow_err, ovf_exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h40,  32'hAAAA, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h40,  32'hAAAA, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 32'h40,  32'hAAAA, 1'b1, 32'hAAAA};
    vecs[3]  = '{1'b1, 32'h80,  32'hBBBB, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 32'h80,  32'hBBBB, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 32'h80,  32'hBBBB, 1'b1, 32'hBBBB};
    vecs[6]  = '{1'b1, 32'h84,  32'h1111, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 32'h84,  32'h1111, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 32'h84,  32'h1111, 1'b1, 32'h1111};
    vecs[9]  = '{1'b1, 32'h88,  32'h2222, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 32'h88,  32'h2222, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 32'h88,  32'h2222, 1'b1, 32'h2222};
    vecs[12] = '{1'b1, 32'h8C,  32'h3333, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 32'h8C,  32'h3333, 1'b0, 32'h0};
    vecs[14] = '{1'b1, 32'h8C,  32'h3333, 1'b1, 32'h3333};
    vecs[15] = '{1'b0, 32'h40,  32'h0,    1'b1, 32'hAAAA};
    vecs[16] = '{1'b0, 32'hC0,  32'h0,    1'b0, 32'h0};
    vecs[17] = '{1'b0, 32'h140, 32'h0,    1'b0, 32'h0};
    vecs[18] = '{1'b0, 32'h80,  32'h0,    1'b1, 32'hBBBB};
    fp[0] = 32'h80; fp[1] = 32'h84; fp[2] = 32'h88; fp[3] = 32'h8C;
    fv[0] = 32'hBBBB; fv[1] = 32'h1111; fv[2] = 32'h2222; fv[3] = 32'h3333;

    // Reset state
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst pred_valid", pred_valid, 0);
    chk("rst spec_full", spec_full, 0);
    chk("rst recover", recover, 0);
    chk("rst recover_pc", recover_pc, 0);
    chk("rst correct", correct, 0);
    chk("rst inflight", inflight_count, 0);
    chk("rst overflow", overflow_err, 0);
    rst_n = 1'b1;
    tick();

    // Training and lookup vectors
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].do_train) train(vecs[i].pc, vecs[i].data);
      lookup_check($sformatf("vec%0d", i), vecs[i].pc, vecs[i].exp_pv, vecs[i].exp_val);
    end

    // Correct path and confidence saturation (2 -> 3 -> 3 -> 3)
    cyc(1'b1, 32'h40, 32'hAAAA, 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'hAAAA);
    tick();
    chk("correct one-cycle", correct, 0);
    cyc(1'b1, 32'h40, 32'hAAAA, 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'hAAAA);
    cyc(1'b1, 32'h40, 32'hAAAA, 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'hAAAA);
    lookup_check("saturated 0x40", 32'h40, 1'b1, 32'hAAAA);

    // Mispredict with two outstanding
    cyc(1'b1, 32'h40, 32'hAAAA, 1'b0, 32'h0);
    cyc(1'b1, 32'h80, 32'hBBBB, 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h1234);
    // RECOVER cycle: recovery_done here must be ignored
    recovery_done = 1'b1;
    lookup_valid  = 1'b1;
    lookup_pc     = 32'h80;
    spec_accept   = 1'b1;
    #1;
    chk("recover pred_valid", pred_valid, 0);
    tick();
    idle();
    chk("recover pulse end", recover, 0);
    chk("recover_pc held", recover_pc, 32'h40);
    chk("recover inflight", inflight_count, 0);
    // WAIT: push and training attempts are ignored
    lookup_valid  = 1'b1;
    lookup_pc     = 32'h80;
    spec_accept   = 1'b1;
    resolve_valid = 1'b1;
    resolve_data  = 32'h9999;
    #1;
    chk("wait pred_valid", pred_valid, 0);
    tick();
    idle();
    chk("wait inflight", inflight_count, 0);
    chk("wait correct", correct, 0);
    lookup_valid = 1'b1;
    lookup_pc    = 32'h80;
    #1;
    chk("still wait pred_valid", pred_valid, 0);
    idle();
    recovery_done = 1'b1;
    tick();
    idle();
    lookup_check("post-recovery 0x80", 32'h80, 1'b1, 32'hBBBB);
    lookup_check("mispredicted 0x40", 32'h40, 1'b0, 32'h0);
    train(32'h40, 32'h1234);
    lookup_check("0x40 conf 1", 32'h40, 1'b0, 32'h0);
    train(32'h40, 32'h1234);
    lookup_check("0x40 new value", 32'h40, 1'b1, 32'h1234);

    // Aliasing: same index, different tag
    train(32'h140, 32'h5555);
    lookup_check("alias old pc", 32'h40, 1'b0, 32'h0);
    lookup_check("alias new conf0", 32'h140, 1'b0, 32'h0);
    train(32'h140, 32'h5555);
    train(32'h140, 32'h5555);
    lookup_check("alias trained", 32'h140, 1'b1, 32'h5555);
    lookup_check("alias old pc again", 32'h40, 1'b0, 32'h0);

    // Full queue, push+pop when full, dropped push, pointer wrap
    for (int i = 0; i < 4; i++) cyc(1'b1, fp[i], fv[i], 1'b0, 32'h0);
    cyc(1'b1, 32'h80, 32'hBBBB, 1'b1, 32'hBBBB);
    cyc(1'b1, 32'h84, 32'h1111, 1'b0, 32'h0);
    for (int k = 0; k < 8; k++) cyc(1'b1, fp[k%4], fv[k%4], 1'b1, sb[0].val);
    for (int k = 0; k < 4; k++) cyc(1'b0, 32'h0, 32'h0, 1'b1, sb[0].val);

    // Flush with three outstanding and a same-cycle push
    for (int i = 0; i < 3; i++) cyc(1'b1, fp[i], fv[i], 1'b0, 32'h0);
    flush        = 1'b1;
    lookup_valid = 1'b1;
    lookup_pc    = 32'h8C;
    spec_accept  = 1'b1;
    tick();
    idle();
    sb.delete();
    chk("flush inflight", inflight_count, 0);
    chk("flush recover", recover, 0);
    chk("flush spec_full", spec_full, 0);
    cyc(1'b1, 32'h8C, 32'h3333, 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h3333);

    // Asynchronous reset while waiting for recovery
    cyc(1'b1, 32'h80, 32'hBBBB, 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'hDEAD);
    tick();
    chk("wait recover_pc", recover_pc, 32'h80);
    chk("sticky overflow", overflow_err, 1);
    lookup_valid = 1'b1;
    lookup_pc    = 32'h84;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst recover_pc", recover_pc, 0);
    chk("async rst overflow", overflow_err, 0);
    chk("async rst inflight", inflight_count, 0);
    chk("async rst recover", recover, 0);
    chk("async rst pred_valid", pred_valid, 0);
    idle();
    @(negedge clk);
    rst_n   = 1'b1;
    ovf_exp = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) train(32'h80, 32'hBBBB);
    lookup_check("run after reset", 32'h80, 1'b1, 32'hBBBB);
    cyc(1'b1, 32'h80, 32'hBBBB, 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'hBBBB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
